// File: rtl/timer_bus_initiator.sv
// Command-driven single-outstanding initiator for the peripheral register bus.
// Turns write, read and poll-until-match commands into single-cycle bus
// accesses. A poll re-reads one register, optionally with idle gap cycles
// between reads, until a masked compare matches or the retry budget is spent.
module timer_bus_initiator #(
    parameter int POLL_MAX = 1024,
    parameter int POLL_GAP = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [31:0] cmd_mask,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        sel,
    output logic        we,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    input  logic [31:0] rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_GAP    = 2'b10,
        ST_RESP   = 2'b11
    } state_t;

    localparam logic [1:0]  OP_WRITE   = 2'b00;
    localparam logic [1:0]  OP_READ    = 2'b01;
    localparam logic [1:0]  OP_POLL    = 2'b10;
    localparam logic [1:0]  OP_RSVD    = 2'b11;
    localparam logic [15:0] POLL_MAX_C = 16'(POLL_MAX);
    // The GAP counter counts down to zero, so it is loaded with POLL_GAP-1.
    localparam logic [15:0] GAP_LOAD_C = (POLL_GAP > 0) ? 16'(POLL_GAP - 1) : 16'd0;
    localparam bit          GAP_EN_C   = (POLL_GAP > 0);

    state_t      state_r;
    logic [1:0]  op_r;
    logic [31:0] cmp_r;
    logic [31:0] mask_r;
    logic [15:0] poll_cnt_r;
    logic [15:0] gap_cnt_r;
    logic [15:0] poll_cnt_inc_s;
    logic        poll_hit_s;

    // Masked equality used by the poll compare; a zero mask always matches.
    function automatic logic masked_match(input logic [31:0] data,
                                          input logic [31:0] cmp,
                                          input logic [31:0] mask);
        return ((data & mask) == (cmp & mask));
    endfunction

    assign poll_cnt_inc_s = poll_cnt_r + 16'd1;
    assign poll_hit_s     = masked_match(rdata, cmp_r, mask_r);

    // Control FSM; every output is a register so rdata/cmd_* never reach an output combinationally.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r    <= ST_IDLE;
            op_r       <= 2'b00;
            cmp_r      <= 32'd0;
            mask_r     <= 32'd0;
            poll_cnt_r <= 16'd0;
            gap_cnt_r  <= 16'd0;
            cmd_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_data   <= 32'd0;
            rsp_err    <= 1'b0;
            sel        <= 1'b0;
            we         <= 1'b0;
            addr       <= 32'd0;
            wdata      <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        op_r       <= cmd_op;
                        cmp_r      <= cmd_wdata;
                        mask_r     <= cmd_mask;
                        poll_cnt_r <= 16'd0;
                        cmd_ready  <= 1'b0;
                        if (cmd_op == OP_RSVD) begin
                            // Reserved op: error response without touching the bus.
                            state_r   <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_data  <= 32'd0;
                            rsp_err   <= 1'b1;
                        end else begin
                            state_r <= ST_ACCESS;
                            sel     <= 1'b1;
                            we      <= (cmd_op == OP_WRITE);
                            addr    <= cmd_addr;
                            wdata   <= (cmd_op == OP_WRITE) ? cmd_wdata : 32'd0;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    sel   <= 1'b0;
                    we    <= 1'b0;
                    wdata <= 32'd0;
                    case (op_r)
                        OP_WRITE: begin
                            state_r   <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_data  <= 32'd0;
                            rsp_err   <= 1'b0;
                        end
                        OP_READ: begin
                            state_r   <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_data  <= rdata;
                            rsp_err   <= 1'b0;
                        end
                        OP_POLL: begin
                            rsp_data   <= rdata;
                            poll_cnt_r <= poll_cnt_inc_s;
                            if (poll_hit_s) begin
                                state_r   <= ST_RESP;
                                rsp_valid <= 1'b1;
                                rsp_err   <= 1'b0;
                            end else if (poll_cnt_inc_s == POLL_MAX_C) begin
                                state_r   <= ST_RESP;
                                rsp_valid <= 1'b1;
                                rsp_err   <= 1'b1;
                            end else if (GAP_EN_C) begin
                                state_r   <= ST_GAP;
                                gap_cnt_r <= GAP_LOAD_C;
                            end else begin
                                // Back-to-back poll: keep select asserted for the next read.
                                state_r <= ST_ACCESS;
                                sel     <= 1'b1;
                            end
                        end
                        default: begin
                            state_r   <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_data  <= 32'd0;
                            rsp_err   <= 1'b1;
                        end
                    endcase
                end
                ST_GAP: begin
                    if (gap_cnt_r == 16'd0) begin
                        state_r <= ST_ACCESS;
                        sel     <= 1'b1;
                    end else begin
                        gap_cnt_r <= gap_cnt_r - 16'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_r   <= ST_IDLE;
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                    end else begin
                        state_r <= ST_RESP;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    cmd_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    sel       <= 1'b0;
                    we        <= 1'b0;
                    wdata     <= 32'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timer_bus_initiator.sv
// Bench for timer_bus_initiator. Unit 0 (POLL_GAP=0) talks to a behavioural
// timer (CTRL 0x00, LOAD 0x04, VALUE 0x08, scratch 0x0C). Unit 1
// (POLL_MAX=3, POLL_GAP=2) talks to a random responder whose data never
// matches a compare value with bit 31 clear under a mask with bit 31 set.
module tb_timer_bus_initiator;

    logic        clk;
    logic        resetn;
    logic        cmd_valid [2];
    logic        cmd_ready [2];
    logic [1:0]  cmd_op    [2];
    logic [31:0] cmd_addr  [2];
    logic [31:0] cmd_wdata [2];
    logic [31:0] cmd_mask  [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_data  [2];
    logic        rsp_err   [2];
    logic        sel       [2];
    logic        we        [2];
    logic [31:0] addr      [2];
    logic [31:0] wdata     [2];
    logic [31:0] rdata_a;
    logic [31:0] rdata_b = 32'h8000_0000;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Bus monitor state
    int          sel_cnt [2] = '{0, 0};
    int          we_cnt  [2] = '{0, 0};
    logic [31:0] last_rd [2];
    logic [31:0] last_ad [2];
    logic [31:0] last_wd [2];
    int          sel_cyc [2][$];

    // Timer register state
    logic [31:0] t_ctrl    = 32'd0;
    logic [31:0] t_load    = 32'd0;
    logic [31:0] t_value   = 32'd0;
    logic [31:0] t_scratch = 32'd0;

    timer_bus_initiator #(.POLL_MAX(16), .POLL_GAP(0)) dut_a (
        .clk(clk), .resetn(resetn),
        .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_op(cmd_op[0]),
        .cmd_addr(cmd_addr[0]), .cmd_wdata(cmd_wdata[0]), .cmd_mask(cmd_mask[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]),
        .rsp_err(rsp_err[0]), .sel(sel[0]), .we(we[0]), .addr(addr[0]),
        .wdata(wdata[0]), .rdata(rdata_a)
    );

    timer_bus_initiator #(.POLL_MAX(3), .POLL_GAP(2)) dut_b (
        .clk(clk), .resetn(resetn),
        .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_op(cmd_op[1]),
        .cmd_addr(cmd_addr[1]), .cmd_wdata(cmd_wdata[1]), .cmd_mask(cmd_mask[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]),
        .rsp_err(rsp_err[1]), .sel(sel[1]), .we(we[1]), .addr(addr[1]),
        .wdata(wdata[1]), .rdata(rdata_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    // Timer read port: combinational while selected
    always_comb begin
        rdata_a = 32'd0;
        if (sel[0]) begin
            case (addr[0])
                32'h00:  rdata_a = t_ctrl;
                32'h04:  rdata_a = t_load;
                32'h08:  rdata_a = t_value;
                32'h0C:  rdata_a = t_scratch;
                default: rdata_a = 32'd0;
            endcase
        end
    end

    // Timer behaviour: down-counter, optional periodic reload; writes land at end of sel cycle
    always @(posedge clk) begin
        if (t_ctrl[0]) begin
            if (t_value == 32'd0) t_value <= t_ctrl[1] ? t_load : 32'd0;
            else                  t_value <= t_value - 32'd1;
        end
        if (sel[0] && we[0]) begin
            case (addr[0])
                32'h00: begin
                    t_ctrl <= wdata[0];
                    if (wdata[0][0]) t_value <= t_load;
                end
                32'h04:  t_load <= wdata[0];
                32'h0C:  t_scratch <= wdata[0];
                default: t_scratch <= t_scratch;
            endcase
        end
    end

    // Random responder for unit 1: bit 31 always set, new value every cycle
    always @(posedge clk) begin
        logic [31:0] r;
        r = $urandom();
        rdata_b <= r | 32'h8000_0000;
    end

    // Bus monitor: count select cycles and remember what was on the bus
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (sel[u]) begin
                sel_cnt[u] = sel_cnt[u] + 1;
                if (we[u]) we_cnt[u] = we_cnt[u] + 1;
                last_rd[u] = (u == 0) ? rdata_a : rdata_b;
                last_ad[u] = addr[u];
                last_wd[u] = wdata[u];
                sel_cyc[u].push_back(cyc);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input int u);
        chk("rst cmd_ready", 32'(cmd_ready[u]), 32'd1);
        chk("rst rsp_valid", 32'(rsp_valid[u]), 32'd0);
        chk("rst rsp_data",  rsp_data[u],       32'd0);
        chk("rst rsp_err",   32'(rsp_err[u]),   32'd0);
        chk("rst sel",       32'(sel[u]),       32'd0);
        chk("rst we",        32'(we[u]),        32'd0);
        chk("rst addr",      addr[u],           32'd0);
        chk("rst wdata",     wdata[u],          32'd0);
    endtask

    // Issue one command, wait for and accept its response
    task automatic run(input int u, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] m,
                       output logic [31:0] rd, output logic er,
                       output int nsel, output int nwe, output int lat);
        int s0;
        int w0;
        int t;
        @(negedge clk);
        s0 = sel_cnt[u];
        w0 = we_cnt[u];
        sel_cyc[u].delete();
        cmd_valid[u] = 1'b1;
        cmd_op[u]    = op;
        cmd_addr[u]  = a;
        cmd_wdata[u] = d;
        cmd_mask[u]  = m;
        t = 0;
        while (!cmd_ready[u] && t < 100) begin @(negedge clk); t++; end
        @(posedge clk); #1;
        cmd_valid[u] = 1'b0;
        lat = 0;
        while (!rsp_valid[u] && lat < 2000) begin @(negedge clk); lat++; end
        chk("rsp timeout", 32'(rsp_valid[u]), 32'd1);
        rd = rsp_data[u];
        er = rsp_err[u];
        rsp_ready[u] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[u] = 1'b0;
        chk("cmd_ready back", 32'(cmd_ready[u]), 32'd1);
        nsel = sel_cnt[u] - s0;
        nwe  = we_cnt[u] - w0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          nsel;
        int          nwe;
        int          lat;
        logic [31:0] m_load;
        logic [31:0] m_scratch;
        logic [31:0] held;
        logic [31:0] rnd;
        logic [1:0]  op;
        logic [31:0] a;
        int          s0;
        int          t;

        m_load    = 32'd0;
        m_scratch = 32'd0;
        for (int u = 0; u < 2; u++) begin
            cmd_valid[u] = 1'b0;
            cmd_op[u]    = 2'b00;
            cmd_addr[u]  = 32'd0;
            cmd_wdata[u] = 32'd0;
            cmd_mask[u]  = 32'd0;
            rsp_ready[u] = 1'b0;
        end
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset(0);
        chk_reset(1);
        resetn = 1'b1;

        // Random writes/reads to LOAD and scratch against a register model
        for (int i = 0; i < 20; i++) begin
            op  = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b01;
            a   = ($urandom_range(0, 1) == 0) ? 32'h04 : 32'h0C;
            rnd = $urandom();
            run(0, op, a, rnd, 32'd0, rd, er, nsel, nwe, lat);
            if (op == 2'b00) begin
                if (a == 32'h04) m_load = rnd; else m_scratch = rnd;
                chk("rnd wr data", rd, 32'd0);
                chk("rnd wr addr", last_ad[0], a);
                chk("rnd wr wdata", last_wd[0], rnd);
            end else begin
                chk("rnd rd data", rd, (a == 32'h04) ? m_load : m_scratch);
            end
            chk("rnd err", 32'(er), 32'd0);
            chk("rnd nsel", 32'(nsel), 32'd1);
            chk("rnd nwe", 32'(nwe), (op == 2'b00) ? 32'd1 : 32'd0);
            chk("rnd latency", 32'(lat), 32'd2);
        end

        // Write LOAD=5, read it back
        run(0, 2'b00, 32'h04, 32'h5, 32'd0, rd, er, nsel, nwe, lat);
        m_load = 32'h5;
        chk("wr nsel", 32'(nsel), 32'd1);
        chk("wr nwe", 32'(nwe), 32'd1);
        chk("wr addr", last_ad[0], 32'h04);
        chk("wr wdata", last_wd[0], 32'h5);
        chk("wr rsp", rd, 32'd0);
        run(0, 2'b01, 32'h04, 32'd0, 32'd0, rd, er, nsel, nwe, lat);
        chk("load rb", rd, 32'h5);

        // Start periodic timer, read CTRL back
        run(0, 2'b00, 32'h00, 32'h3, 32'd0, rd, er, nsel, nwe, lat);
        run(0, 2'b01, 32'h00, 32'd0, 32'd0, rd, er, nsel, nwe, lat);
        chk("ctrl rb", rd, 32'h3);
        chk("ctrl rb err", 32'(er), 32'd0);
        chk("ctrl rb nsel", 32'(nsel), 32'd1);
        chk("ctrl rb nwe", 32'(nwe), 32'd0);

        // Poll VALUE until zero, back-to-back reads
        run(0, 2'b10, 32'h08, 32'd0, 32'hFFFF_FFFF, rd, er, nsel, nwe, lat);
        chk("poll ok data", rd, 32'd0);
        chk("poll ok err", 32'(er), 32'd0);
        chk("poll ok <=7 reads", 32'(nsel >= 1 && nsel <= 7), 32'd1);
        chk("poll ok nwe", 32'(nwe), 32'd0);
        for (int k = 1; k < sel_cyc[0].size(); k++)
            chk("poll ok spacing", 32'(sel_cyc[0][k] - sel_cyc[0][k-1]), 32'd1);

        // Backpressure: response held, new command ignored
        run(0, 2'b00, 32'h00, 32'h0, 32'd0, rd, er, nsel, nwe, lat);
        @(negedge clk);
        cmd_valid[0] = 1'b1;
        cmd_op[0]    = 2'b01;
        cmd_addr[0]  = 32'h04;
        @(posedge clk); #1;
        cmd_op[0]    = 2'b00;
        cmd_addr[0]  = 32'h0C;
        cmd_wdata[0] = ~m_scratch;
        t = 0;
        while (!rsp_valid[0] && t < 100) begin @(negedge clk); t++; end
        held = rsp_data[0];
        chk("bp data", held, m_load);
        s0 = sel_cnt[0];
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("bp rsp_valid", 32'(rsp_valid[0]), 32'd1);
            chk("bp rsp_data", rsp_data[0], held);
            chk("bp cmd_ready", 32'(cmd_ready[0]), 32'd0);
        end
        chk("bp no sel", 32'(sel_cnt[0] - s0), 32'd0);
        cmd_valid[0] = 1'b0;
        rsp_ready[0] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[0] = 1'b0;
        run(0, 2'b01, 32'h0C, 32'd0, 32'd0, rd, er, nsel, nwe, lat);
        chk("bp cmd not taken", rd, m_scratch);

        // Reserved op
        run(0, 2'b11, 32'h04, 32'h1234, 32'd0, rd, er, nsel, nwe, lat);
        chk("rsvd err", 32'(er), 32'd1);
        chk("rsvd data", rd, 32'd0);
        chk("rsvd nsel", 32'(nsel), 32'd0);

        // Poll exhaustion on unit 1
        rnd = $urandom();
        run(1, 2'b10, 32'h20, rnd & 32'h7FFF_FFFF, $urandom() | 32'h8000_0000,
            rd, er, nsel, nwe, lat);
        chk("exh nsel", 32'(nsel), 32'd3);
        chk("exh err", 32'(er), 32'd1);
        chk("exh data", rd, last_rd[1]);
        chk("exh addr", last_ad[1], 32'h20);
        if (sel_cyc[1].size() == 3) begin
            chk("exh gap1", 32'(sel_cyc[1][1] - sel_cyc[1][0]), 32'd3);
            chk("exh gap2", 32'(sel_cyc[1][2] - sel_cyc[1][1]), 32'd3);
        end else begin
            chk("exh sel count", 32'(sel_cyc[1].size()), 32'd3);
        end

        // Mask 0 matches on the first read
        run(1, 2'b10, 32'h24, 32'h1, 32'd0, rd, er, nsel, nwe, lat);
        chk("mask0 nsel", 32'(nsel), 32'd1);
        chk("mask0 err", 32'(er), 32'd0);
        chk("mask0 data", rd, last_rd[1]);

        // Reset while unit 1 sits in GAP
        @(negedge clk);
        cmd_valid[1] = 1'b1;
        cmd_op[1]    = 2'b10;
        cmd_addr[1]  = 32'h28;
        cmd_wdata[1] = 32'd0;
        cmd_mask[1]  = 32'h8000_0000;
        @(posedge clk); #1;
        cmd_valid[1] = 1'b0;
        t = 0;
        while (sel[1] && t < 20) begin @(negedge clk); t++; end
        chk("in gap sel", 32'(sel[1]), 32'd0);
        chk("in gap busy", 32'(cmd_ready[1]), 32'd0);
        #2;
        resetn = 1'b0;
        #1;
        chk_reset(1);
        chk_reset(0);
        @(negedge clk);
        resetn = 1'b1;
        run(1, 2'b01, 32'h2C, 32'd0, 32'd0, rd, er, nsel, nwe, lat);
        chk("post rst data", rd, last_rd[1]);
        chk("post rst err", 32'(er), 32'd0);
        chk("post rst nsel", 32'(nsel), 32'd1);
        chk("post rst lat", 32'(lat), 32'd2);
        chk("post rst addr", last_ad[1], 32'h2C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/timer_bus_initiator.md
# timer_bus_initiator

Single-outstanding command-driven initiator for the peripheral register bus (sel/we/addr/wdata/rdata). It turns write, read and poll-until-match commands into single-cycle bus accesses. It sits between a control FSM or test sequencer and memory-mapped peripherals such as the timer. Poll commands repeatedly read one register until a masked compare matches or a retry budget runs out, with no software involvement.

## Interface
- POLL_MAX, 1024: maximum bus reads per poll command; legal range 1 to 2^16-1.
- POLL_GAP, 4: idle cycles between consecutive poll reads; 0 is legal and means back-to-back reads.
- clk  in  1  clock, rising-edge.
- resetn  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_op  in  2  command type: 00 write, 01 read, 10 poll, 11 reserved.
- cmd_addr  in  32  register address.
- cmd_wdata  in  32  write data for writes; compare value for polls.
- cmd_mask  in  32  compare mask for polls; ignored otherwise.
- rsp_valid  out  1  response pending.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_data  out  32  read data, or last polled data; 0 for writes.
- rsp_err  out  1  poll exhausted, or reserved op.
- sel  out  1  bus select.
- we  out  1  bus write enable.
- addr  out  32  bus address.
- wdata  out  32  bus write data.
- rdata  in  32  bus read data, combinational from responder, valid in the same cycle as sel.

## Operation
- FSM states: IDLE, ACCESS, GAP, RESP. Reset state is IDLE.
- IDLE
  - cmd_ready=1.
  - On handshake, latch op/addr/wdata/mask and clear poll_cnt.
  - Op 11 goes directly to RESP with rsp_err=1 and rsp_data=0, and makes no bus access.
  - All other ops go to ACCESS.
- ACCESS (exactly one cycle)
  - Drive sel=1, addr=latched addr, and we=1 only for writes; wdata=latched wdata for writes, 0 otherwise.
  - Write: rsp_data=0, rsp_err=0, then RESP.
  - Read: rsp_data=rdata sampled at the end of this cycle, rsp_err=0, then RESP.
  - Poll: rsp_data=rdata and poll_cnt increments.
    - If (rdata & mask) == (wdata & mask): rsp_err=0, then RESP.
    - Else if poll_cnt has reached POLL_MAX: rsp_err=1, then RESP.
    - Else GAP, or straight back to ACCESS when POLL_GAP=0.
- GAP
  - sel=0 and we=0.
  - Counter runs POLL_GAP cycles, then returns to ACCESS.
- RESP
  - rsp_valid=1; rsp_data and rsp_err are held stable.
  - On rsp_ready, return to IDLE.
  - cmd_ready=0 throughout; there is no command/response overlap.
- Outputs sel, we, addr, wdata, rsp_* and cmd_ready are all registered or decoded from registered state. There is no combinational path from rdata or cmd_* to any output.
- Outside ACCESS: sel=0 and we=0; addr holds its last driven value; wdata=0.
- Mask 0 always matches, so a poll with mask 0 completes on its first read.

## Timing
- Reset values: cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, sel=0, we=0, addr=0, wdata=0.
- Assertion of resetn aborts any operation immediately: sel drops asynchronously and any pending response is discarded.
- Write/read latency:
  - Command handshake at edge N.
  - sel high during cycle N+1.
  - rsp_valid high from N+2.
  - If rsp_ready is already high, cmd_ready returns at N+3.
- A responder write takes effect at the end of the sel cycle.
- Poll reads are spaced exactly POLL_GAP+1 cycles apart (sel-to-sel).
- Worst-case poll duration: POLL_MAX + (POLL_MAX-1)*POLL_GAP cycles of bus activity.
- poll_cnt is 16 bits wide; the compare uses == POLL_MAX after increment, so it never wraps.
- A rsp_ready asserted while rsp_valid=0 is ignored.
- A cmd_valid asserted while cmd_ready=0 is ignored; the command is not latched.

## Test plan
- Write: op 00, addr 0x04, wdata 0x5, with the timer as responder.
  - Exactly one sel=we=1 cycle with addr=0x04, wdata=0x5.
  - Timer LOAD reads back 0x5; response rsp_data=0, rsp_err=0.
- Read after write: write CTRL 0x3, then op 01 at addr 0x00.
  - rsp_data=0x3, rsp_err=0.
  - sel is high exactly one cycle per command, and we=0 on the read.
- Poll success: LOAD=0x5 with periodic timer running, then op 10 at addr 0x08, wdata 0, mask 0xFFFFFFFF, POLL_GAP=0.
  - Completes when VALUE=0 with rsp_data=0, rsp_err=0.
  - Completes within 7 reads.
- Poll exhaustion: POLL_MAX=3, POLL_GAP=2, polling a register that never matches.
  - Exactly 3 sel pulses, 3 cycles apart.
  - Response has rsp_err=1 and rsp_data equal to the last value read.
- Backpressure and reserved op:
  - Hold rsp_ready=0 for 10 cycles: rsp_valid and rsp_data stay stable, cmd_ready=0, and a cmd_valid offered during this time is not taken.
  - Op 11: rsp_err=1 with no sel pulse.
- Reset mid-poll: drop resetn while in GAP.
  - All outputs return to reset values immediately.
  - After release, a new read works normally.
